// File: rtl/img_udp_framer_pkg.sv
// Shared types and constants for the image-to-UDP packetiser.
package img_udp_framer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_PREFETCH,
    ST_START,
    ST_SEND,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  localparam logic [31:0] FRAME_HEAD_DEF = 32'hF05A_A50F;
  localparam int          HEAD_BYTES     = 4;
  localparam int          PIX_BYTES      = 2;

  // Payload size of one line packet; the frame header only rides on line 0.
  function automatic logic [15:0] line_bytes(input int h_pixel, input logic with_head);
    return 16'(h_pixel * PIX_BYTES + (with_head ? HEAD_BYTES : 0));
  endfunction

endpackage

// File: rtl/img_udp_framer_pix.sv
// Two-pixel read sequencer plus 16->32 prefetch register.
// A fill pulse at cycle t raises img_req at t+1 and t+2; the FIFO answers one
// cycle later, so the packed word {p_first, p_second} is complete at t+4.
module img_pix_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fill_i,
  input  logic [15:0] pix_i,
  output logic        img_req_o,
  output logic        full_o,
  output logic [31:0] word_o
);

  logic [1:0]  req_left_q;
  logic        vld_q;
  logic        last_q;
  logic        full_q;
  logic [31:0] word_q;

  assign img_req_o = (req_left_q != 2'd0);
  assign full_o    = full_q;
  assign word_o    = word_q;

  // Read-request counter and capture pipeline tracking which half arrives next.
  // NOTE: every register here is updated with <= so all flops see the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_left_q <= 2'd0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      if (fill_i)         req_left_q <= 2'd2;
      else if (img_req_o) req_left_q <= req_left_q - 2'd1;
      vld_q  <= img_req_o;
      last_q <= (req_left_q == 2'd1);
      if (fill_i)                full_q <= 1'b0;
      else if (vld_q && last_q)  full_q <= 1'b1;
    end
  end

  // Prefetch word: first pixel lands in the upper half, second in the lower.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 32'd0;
    end else if (vld_q) begin
      if (last_q) word_q[15:0]  <= pix_i;
      else        word_q[31:16] <= pix_i;
    end
  end

endmodule

// File: rtl/img_udp_framer.sv
// Packetises the SDRAM pixel stream into one UDP payload per image line,
// two RGB565 pixels per word, with a frame header word ahead of line 0.
module img_udp_framer
  import img_udp_framer_pkg::*;
#(
  parameter int          CMOS_H_PIXEL = 640,
  parameter int          CMOS_V_PIXEL = 480,
  parameter logic [31:0] FRAME_HEAD   = FRAME_HEAD_DEF,
  parameter logic [23:0] START_DLY    = 24'd1_000_000,
  parameter logic [15:0] PKT_GAP      = 16'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] img_data,
  output logic        img_req,
  input  logic        udp_tx_req,
  input  logic        udp_tx_done,
  output logic        udp_tx_start_en,
  output logic [31:0] udp_tx_data,
  output logic [15:0] udp_tx_byte_num,
  output logic [15:0] frame_cnt
);

  localparam logic [23:0] START_LAST = START_DLY - 24'd1;
  localparam logic [23:0] GAP_LAST   = {8'd0, PKT_GAP} - 24'd1;
  localparam logic [15:0] PIX_WORDS  = 16'(CMOS_H_PIXEL / 2);
  localparam logic [15:0] LINE_LAST  = 16'(CMOS_V_PIXEL - 1);

  state_e      state_q, state_d;
  logic [23:0] dly_q;
  logic [15:0] words_q;
  logic [15:0] line_q;
  logic [15:0] frame_q;
  logic        head_pend_q;
  logic [31:0] data_q;
  logic [15:0] byte_num_q;

  logic        pack_full;
  logic [31:0] pack_word;
  logic        fill;
  logic        req_acc;
  logic        pix_acc;
  logic        last_pix;
  logic        done_acc;
  logic        line_wrap;
  logic        enter_start;

  // A request only counts inside SEND while words remain in the packet.
  assign req_acc     = (state_q == ST_SEND) && udp_tx_req && (words_q != 16'd0);
  assign pix_acc     = req_acc && !head_pend_q;
  assign last_pix    = pix_acc && (words_q == 16'd1);
  assign done_acc    = (state_q == ST_WAIT_DONE) && udp_tx_done;
  assign line_wrap   = (line_q == LINE_LAST);
  assign enter_start = (state_d == ST_START) && (state_q != ST_START);
  // Fill on entry to PREFETCH, and after each pixel word that is not the last.
  assign fill = ((state_d == ST_PREFETCH) && (state_q != ST_PREFETCH)) ||
                (pix_acc && (words_q != 16'd1));

  img_pix_pack u_pix (
    .clk       (clk),
    .rst_n     (rst_n),
    .fill_i    (fill),
    .pix_i     (img_data),
    .img_req_o (img_req),
    .full_o    (pack_full),
    .word_o    (pack_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WAIT_INIT;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_INIT: if (dly_q == START_LAST) state_d = ST_PREFETCH;
      ST_PREFETCH:  if (pack_full)           state_d = ST_START;
      ST_START:                              state_d = ST_SEND;
      ST_SEND:      if (last_pix)            state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (udp_tx_done)         state_d = ST_GAP;
      ST_GAP:       if (dly_q == GAP_LAST)   state_d = ST_PREFETCH;
      default:                               state_d = ST_WAIT_INIT;
    endcase
  end

  // Output logic: start pulse is exactly the single START cycle.
  always_comb begin
    udp_tx_start_en = (state_q == ST_START);
  end

  // Shared idle counter for the start-up delay and the inter-packet gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= 24'd0;
    end else if ((state_q == ST_WAIT_INIT || state_q == ST_GAP) && state_d == state_q) begin
      dly_q <= dly_q + 24'd1;
    end else begin
      dly_q <= 24'd0;
    end
  end

  // Packet setup on entry to START and per-word payload output in SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_num_q  <= 16'd0;
      words_q     <= 16'd0;
      data_q      <= 32'd0;
      head_pend_q <= 1'b1;
    end else begin
      if (enter_start) begin
        byte_num_q <= line_bytes(CMOS_H_PIXEL, line_q == 16'd0);
        words_q    <= PIX_WORDS + 16'(line_q == 16'd0);
      end else if (req_acc) begin
        words_q <= words_q - 16'd1;
      end
      if (req_acc) data_q <= head_pend_q ? FRAME_HEAD : pack_word;
      if (req_acc && head_pend_q)      head_pend_q <= 1'b0;
      else if (done_acc && line_wrap)  head_pend_q <= 1'b1;
    end
  end

  // Line and frame counters advance when the engine reports the packet sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= 16'd0;
      frame_q <= 16'd0;
    end else if (done_acc) begin
      line_q <= line_wrap ? 16'd0 : line_q + 16'd1;
      if (line_wrap) frame_q <= frame_q + 16'd1;
    end
  end

  assign udp_tx_data     = data_q;
  assign udp_tx_byte_num = byte_num_q;
  assign frame_cnt       = frame_q;

endmodule

// File: tb/tb_img_udp_framer.sv
// Self-checking bench for img_udp_framer with H=8, V=2, START_DLY=100.
module tb_img_udp_framer;

  localparam int          H       = 8;
  localparam int          V       = 2;
  localparam int          DLY     = 100;
  localparam logic [31:0] HEAD    = 32'hF05A_A50F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] img_data;
  logic        img_req;
  logic        udp_tx_req;
  logic        udp_tx_done;
  logic        udp_tx_start_en;
  logic [31:0] udp_tx_data;
  logic [15:0] udp_tx_byte_num;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int req_cnt = 0;
  bit early = 1'b0;

  // Reference model state: line/frame position and stream offset.
  int line_no = 0;
  int frame_no = 0;
  int pix_base = 0;

  // Upstream FIFO model: pixel store read sequentially, data one cycle after req.
  logic [15:0] pix_mem [256];
  logic [7:0]  rd_ptr;

  img_udp_framer #(
    .CMOS_H_PIXEL (H),
    .CMOS_V_PIXEL (V),
    .FRAME_HEAD   (HEAD),
    .START_DLY    (24'(DLY)),
    .PKT_GAP      (16'd16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .img_data        (img_data),
    .img_req         (img_req),
    .udp_tx_req      (udp_tx_req),
    .udp_tx_done     (udp_tx_done),
    .udp_tx_start_en (udp_tx_start_en),
    .udp_tx_data     (udp_tx_data),
    .udp_tx_byte_num (udp_tx_byte_num),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= 8'd0;
      img_data <= 16'd0;
    end else if (img_req) begin
      img_data <= pix_mem[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; observe at the following falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (img_req === 1'b1) req_cnt++;
    if (cyc < DLY && (img_req === 1'b1 || udp_tx_start_en === 1'b1)) early = 1'b1;
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (udp_tx_start_en !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(udp_tx_start_en), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_img_req"},  32'(img_req),         32'd0);
    chk({tag, "_start_en"}, 32'(udp_tx_start_en), 32'd0);
    chk({tag, "_data"},     udp_tx_data,          32'd0);
    chk({tag, "_byte_num"}, 32'(udp_tx_byte_num), 32'd0);
    chk({tag, "_frame"},    32'(frame_cnt),       32'd0);
  endtask

  // Drive one packet from its START cycle; stop_after>0 abandons it mid-SEND.
  task automatic do_packet(input int fixed_gap, input int stop_after, input bit spurious);
    logic [31:0] exp_q[$];
    int g;
    exp_q = {};
    if (line_no == 0) exp_q.push_back(HEAD);
    for (int j = 0; j < H / 2; j++)
      exp_q.push_back({pix_mem[(pix_base + 2 * j) % 256], pix_mem[(pix_base + 2 * j + 1) % 256]});
    chk("byte_num", 32'(udp_tx_byte_num), 32'((line_no == 0) ? H * 2 + 4 : H * 2));
    chk("frame_cnt_at_start", 32'(frame_cnt), 32'(frame_no));
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(3, 9));
      repeat (g) tick();
      udp_tx_req = 1'b1;
      tick();
      udp_tx_req = 1'b0;
      chk($sformatf("line%0d_word%0d", line_no, k), udp_tx_data, exp_q[k]);
      if (spurious && k == 1) begin
        repeat (3) tick();
        udp_tx_done = 1'b1;
        tick();
        udp_tx_done = 1'b0;
        chk("spur_done_img_req", 32'(img_req), 32'd0);
        chk("spur_done_data", udp_tx_data, exp_q[k]);
      end
      if (k + 1 == stop_after) return;
    end
    repeat (4) tick();
    chk("img_req_per_line", 32'(req_cnt), 32'(H));
    udp_tx_done = 1'b1;
    tick();
    udp_tx_done = 1'b0;
    req_cnt = 0;
    pix_base += H;
    line_no++;
    if (line_no == V) begin
      line_no = 0;
      frame_no++;
    end
    chk("frame_cnt_after_done", 32'(frame_cnt), 32'(frame_no));
    if (spurious) begin
      udp_tx_req = 1'b1;
      tick();
      udp_tx_req = 1'b0;
      chk("spur_req_data", udp_tx_data, exp_q[exp_q.size() - 1]);
      chk("spur_req_img_req", 32'(img_req), 32'd0);
      repeat (2) tick();
      chk("spur_req_no_refill", 32'(req_cnt), 32'd0);
    end
  endtask

  task automatic restart_model();
    line_no  = 0;
    frame_no = 0;
    pix_base = 0;
    req_cnt  = 0;
    cyc      = 0;
    early    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      pix_mem[i] = (i < H) ? 16'(i + 1) : 16'($urandom);
    rst_n       = 1'b0;
    udp_tx_req  = 1'b0;
    udp_tx_done = 1'b0;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    restart_model();

    // Start-up delay, then line 0 with fixed 8-cycle request spacing.
    wait_start(300);
    chk("start_cycle_window", 32'(cyc >= DLY && cyc <= DLY + 4), 32'd1);
    chk("no_early_activity", 32'(early), 32'd0);
    do_packet(7, 0, 1'b1);

    // Line 1, then frame wrap back to a header packet, then line 1 again.
    wait_start(300);
    do_packet(0, 0, 1'b0);
    wait_start(300);
    do_packet(0, 0, 1'b1);
    wait_start(300);
    do_packet(0, 0, 1'b0);

    // Header packet interrupted by reset after two words.
    wait_start(300);
    do_packet(0, 2, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    restart_model();
    wait_start(300);
    chk("restart_cycle_window", 32'(cyc >= DLY && cyc <= DLY + 4), 32'd1);
    chk("restart_no_early", 32'(early), 32'd0);
    do_packet(0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
